// File: rtl/stream_merge2_pkg.sv
// -----------------------------------------------------------------------------
// sorter_pkg
// Shared definitions for the sorter datapath.
//   state_e  : merge FSM states (MERGE, DRAIN_A, DRAIN_B)
//   DIR_ASC / DIR_DESC : values of the direction input
//   key_of() : extracts the key (upper half) of a record of width w
// Records are at most REC_MAX_W bits wide. Callers zero-extend the record
// before calling key_of().
// -----------------------------------------------------------------------------
package sorter_pkg;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_e;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  localparam int REC_MAX_W = 64;

  // Key = bits [w-1:w/2] of the record, returned right-aligned.
  function automatic logic [REC_MAX_W-1:0] key_of(input logic [REC_MAX_W-1:0] rec,
                                                  input int w);
    logic [REC_MAX_W-1:0] mask;
    mask = ({{(REC_MAX_W-1){1'b0}}, 1'b1} << (w / 2)) - {{(REC_MAX_W-1){1'b0}}, 1'b1};
    return (rec >> (w / 2)) & mask;
  endfunction

endpackage

// File: rtl/stream_merge2_if.sv
// -----------------------------------------------------------------------------
// stream_merge2_if
// One record stream of the sorter datapath.
//   data  : record, key in [W-1:W/2], information in [W/2-1:0]
//   valid : data/last are meaningful this cycle
//   last  : final record of the current run / merged sequence
//   ready : sink accepts this cycle
// Handshake: a record moves on a rising clock edge where valid and ready are
// both 1. Once valid is raised, data/last/valid hold until that transfer.
// valid never depends on ready; ready may depend on valid.
// Modports: master drives data/valid/last, slave drives ready.
// -----------------------------------------------------------------------------
interface stream_merge2_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/stream_merge2_out_reg.sv
// -----------------------------------------------------------------------------
// merge_out_reg
// Output register stage of stream_merge2. Holds data/valid/last while the
// downstream stalls and reports whether a new record may be accepted.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push_i          : a record is accepted this cycle (only legal when space_o)
//   push_data_i     : record to register
//   push_last_i     : last flag to register
//   out_ready_i     : downstream accept
//   out_data_o      : registered record (0 after reset)
//   out_valid_o     : registered record valid
//   out_last_o      : registered last flag
//   space_o         : register empty or being drained this cycle
// -----------------------------------------------------------------------------
module merge_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         push_last_i,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  output logic         out_last_o,
  output logic         space_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;

  assign space_o = !valid_q || out_ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    // Without space the register simply holds its contents.
    if (space_o) begin
      valid_d = push_i;
      if (push_i) begin
        data_d = push_data_i;
        last_d = push_last_i;
      end else begin
        last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/stream_merge2.sv
// -----------------------------------------------------------------------------
// stream_merge2
// Two-way streaming merge for the sorter datapath. Merges two pre-sorted runs
// (A and B) into one sorted sequence, one record per cycle, ties going to A.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   direction    : 0 ascending, 1 descending; latched at the first pop of
//                  every merged sequence
//   a_if, b_if   : input streams (slave modport)
//   out_if       : merged output stream (master modport), registered
//   seq_cnt      : length of the last completed merged sequence, saturating
//                  (present only when STREAM_MERGE_CNT_EN is defined)
//   state_dbg_o  : current merge FSM state
// Build option: define STREAM_MERGE_CNT_EN to add the sequence-length counter.
// -----------------------------------------------------------------------------
module stream_merge2
  import sorter_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               direction,
  stream_merge2_if.slave     a_if,
  stream_merge2_if.slave     b_if,
  stream_merge2_if.master    out_if,
`ifdef STREAM_MERGE_CNT_EN
  output logic [CNT_W-1:0]   seq_cnt,
`endif
  output state_e             state_dbg_o
);

  state_e state_q, state_d;
  logic   first_q, first_d;
  logic   dir_q, dir_d;

  logic                 space;
  logic                 a_rdy, b_rdy;
  logic                 push;
  logic [W-1:0]         push_data;
  logic                 push_last;
  logic                 dir_eff;
  logic                 a_wins;
  logic [REC_MAX_W-1:0] key_a, key_b;

  assign key_a = key_of(REC_MAX_W'(a_if.data), W);
  assign key_b = key_of(REC_MAX_W'(b_if.data), W);

  // The first pop of a sequence compares with the live input; later pops use
  // the latched direction so a mid-sequence change cannot corrupt ordering.
  assign dir_eff = first_q ? direction : dir_q;
  assign a_wins  = (dir_eff == DIR_DESC) ? (key_a >= key_b) : (key_a <= key_b);

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    dir_d     = dir_q;
    a_rdy     = 1'b0;
    b_rdy     = 1'b0;
    push      = 1'b0;
    push_data = a_if.data;
    push_last = 1'b0;

    case (state_q)
      MERGE: begin
        // Both heads are needed to pick a winner; otherwise stall.
        if (a_if.valid && b_if.valid) begin
          if (a_wins) begin
            a_rdy     = space;
            push      = space;
            push_data = a_if.data;
            if (space && a_if.last) state_d = DRAIN_B;
          end else begin
            b_rdy     = space;
            push      = space;
            push_data = b_if.data;
            if (space && b_if.last) state_d = DRAIN_A;
          end
        end
        if (push && first_q) begin
          first_d = 1'b0;
          dir_d   = direction;
        end
      end
      DRAIN_A: begin
        a_rdy     = space;
        push      = space && a_if.valid;
        push_data = a_if.data;
        push_last = a_if.last;
        if (push && a_if.last) begin
          state_d = MERGE;
          first_d = 1'b1;
        end
      end
      DRAIN_B: begin
        b_rdy     = space;
        push      = space && b_if.valid;
        push_data = b_if.data;
        push_last = b_if.last;
        if (push && b_if.last) begin
          state_d = MERGE;
          first_d = 1'b1;
        end
      end
      default: begin
        state_d = MERGE;
        first_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MERGE;
      first_q <= 1'b1;
      dir_q   <= DIR_ASC;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      dir_q   <= dir_d;
    end
  end

  // space is 1 during reset (out_valid is cleared), so gate readies on rst.
  assign a_if.ready  = a_rdy && !rst;
  assign b_if.ready  = b_rdy && !rst;
  assign state_dbg_o = state_q;

  merge_out_reg #(.W(W)) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .push_last_i (push_last),
    .out_ready_i (out_if.ready),
    .out_data_o  (out_if.data),
    .out_valid_o (out_if.valid),
    .out_last_o  (out_if.last),
    .space_o     (space)
  );

`ifdef STREAM_MERGE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d     = cnt_q;
    seq_cnt_d = seq_cnt_q;
    if (out_if.valid && out_if.ready) begin
      if (out_if.last) begin
        // The closing beat counts toward the reported length.
        seq_cnt_d = cnt_inc;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      seq_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign seq_cnt = seq_cnt_q;
`endif

endmodule

// File: tb/tb_stream_merge2.sv
// -----------------------------------------------------------------------------
// tb_stream_merge2
// Bench for stream_merge2 (W=16). Vector table of merge cases plus hand-coded
// sequences for backpressure and asynchronous reset. Output beats are checked
// against an expected queue.
// -----------------------------------------------------------------------------
module tb_stream_merge2;
  import sorter_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic direction = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  stream_merge2_if #(.W(W)) a_if ();
  stream_merge2_if #(.W(W)) b_if ();
  stream_merge2_if #(.W(W)) o_if ();
  state_e state_dbg;
`ifdef STREAM_MERGE_CNT_EN
  logic [7:0] seq_cnt;
`endif

  stream_merge2 #(.W(W), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .direction   (direction),
    .a_if        (a_if),
    .b_if        (b_if),
    .out_if      (o_if),
`ifdef STREAM_MERGE_CNT_EN
    .seq_cnt     (seq_cnt),
`endif
    .state_dbg_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [W:0] a_q[$];    // {last, data}
  logic [W:0] b_q[$];
  logic [W:0] exp_q[$];
  int beat_n = 0;
  int first_beat_cyc = 0;
  int last_beat_cyc = 0;
  int fire_cyc = 0;
  logic bp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_if.valid && o_if.ready) begin
      if (beat_n == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beat_n++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL out_unexpected: got %0h expected no beat", {o_if.last, o_if.data});
      end else begin
        chk("out_beat", 32'({o_if.last, o_if.data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) o_if.ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_seq(input logic toggle, input int budget);
    logic popped = 1'b0;
    logic toggled = 1'b0;
    logic done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      a_if.valid = (a_q.size() > 0);
      if (a_q.size() > 0) {a_if.last, a_if.data} = a_q[0];
      b_if.valid = (b_q.size() > 0);
      if (b_q.size() > 0) {b_if.last, b_if.data} = b_q[0];
      @(negedge clk);
      if (a_if.valid && a_if.ready) begin
        void'(a_q.pop_front());
        if (!popped) fire_cyc = cyc;
        popped = 1'b1;
      end
      if (b_if.valid && b_if.ready) begin
        void'(b_q.pop_front());
        if (!popped) fire_cyc = cyc;
        popped = 1'b1;
      end
      @(posedge clk);
      #1;
      if (toggle && popped && !toggled) begin
        direction = ~direction;
        toggled = 1'b1;
      end
      done = (a_q.size() == 0) && (b_q.size() == 0) && (exp_q.size() == 0);
    end
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL seq_timeout: got %0d pending expected 0", exp_q.size());
      a_q.delete();
      b_q.delete();
      exp_q.delete();
    end
  endtask

  // Runs are listed first record in the most significant 16 bits.
  typedef struct packed {
    logic         dir;
    logic         toggle;
    logic         bp;
    logic [2:0]   a_len;
    logic [2:0]   b_len;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int n;
    n = int'(v.a_len) + int'(v.b_len);
    direction = v.dir;
    bp_en = v.bp;
    o_if.ready = 1'b1;
    beat_n = 0;
    for (int i = 0; i < int'(v.a_len); i++)
      a_q.push_back({(i == int'(v.a_len) - 1), v.a[63-16*i -: 16]});
    for (int i = 0; i < int'(v.b_len); i++)
      b_q.push_back({(i == int'(v.b_len) - 1), v.b[63-16*i -: 16]});
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), v.exp[127-16*i -: 16]});
    drive_seq(v.toggle, 400);
    bp_en = 1'b0;
    o_if.ready = 1'b1;
    chk("beat_count", 32'(beat_n), 32'(n));
    if (!v.bp) begin
      chk("first_latency", 32'(first_beat_cyc - fire_cyc), 32'd1);
      chk("no_bubble", 32'(last_beat_cyc - first_beat_cyc), 32'(n - 1));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{dir:1'b0, toggle:1'b0, bp:1'b0, a_len:3'd2, b_len:3'd2,
                a:64'h10AA_30BB_0000_0000, b:64'h20CC_40DD_0000_0000,
                exp:128'h10AA_20CC_30BB_40DD_0000_0000_0000_0000};
    vecs[1] = '{dir:1'b1, toggle:1'b1, bp:1'b0, a_len:3'd2, b_len:3'd2,
                a:64'h50A1_20A2_0000_0000, b:64'h40B1_10B2_0000_0000,
                exp:128'h50A1_40B1_20A2_10B2_0000_0000_0000_0000};
    vecs[2] = '{dir:1'b0, toggle:1'b0, bp:1'b0, a_len:3'd1, b_len:3'd1,
                a:64'h5001_0000_0000_0000, b:64'h5002_0000_0000_0000,
                exp:128'h5001_5002_0000_0000_0000_0000_0000_0000};
    vecs[3] = '{dir:1'b1, toggle:1'b0, bp:1'b0, a_len:3'd1, b_len:3'd1,
                a:64'h5001_0000_0000_0000, b:64'h5002_0000_0000_0000,
                exp:128'h5001_5002_0000_0000_0000_0000_0000_0000};
    vecs[4] = '{dir:1'b0, toggle:1'b0, bp:1'b0, a_len:3'd1, b_len:3'd3,
                a:64'h0101_0000_0000_0000, b:64'h0202_0303_0404_0000,
                exp:128'h0101_0202_0303_0404_0000_0000_0000_0000};
    vecs[5] = '{dir:1'b0, toggle:1'b0, bp:1'b1, a_len:3'd3, b_len:3'd1,
                a:64'h1111_3333_5555_0000, b:64'h2222_0000_0000_0000,
                exp:128'h1111_2222_3333_5555_0000_0000_0000_0000};
    vecs[6] = '{dir:1'b1, toggle:1'b0, bp:1'b1, a_len:3'd4, b_len:3'd3,
                a:64'h9001_7002_7003_1004, b:64'h8001_7004_2002_0000,
                exp:128'h9001_8001_7002_7003_7004_2002_1004_0000};

    // Reset state, with valid inputs present to show readies are gated.
    a_if.valid = 1'b1; a_if.data = 16'h1234; a_if.last = 1'b0;
    b_if.valid = 1'b1; b_if.data = 16'h5678; b_if.last = 1'b0;
    o_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(o_if.valid), 32'd0);
    chk("rst_out_data", 32'(o_if.data), 32'd0);
    chk("rst_out_last", 32'(o_if.last), 32'd0);
    chk("rst_a_ready", 32'(a_if.ready), 32'd0);
    chk("rst_b_ready", 32'(b_if.ready), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(MERGE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // MERGE stalls with only B valid.
    a_if.valid = 1'b0;
    b_if.data = 16'h0202;
    repeat (2) begin
      @(negedge clk);
      chk("stall_b_ready", 32'(b_if.ready), 32'd0);
      chk("stall_a_ready", 32'(a_if.ready), 32'd0);
      chk("stall_out_valid", 32'(o_if.valid), 32'd0);
    end
    @(posedge clk);
    #1;
    b_if.valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
`ifdef STREAM_MERGE_CNT_EN
      if (i == 0) chk("seq_cnt_asc", 32'(seq_cnt), 32'd4);
`endif
    end

    // Backpressure: out_ready low while the first record sits in the register.
    exp_q.push_back({1'b0, 16'h10AA});
    exp_q.push_back({1'b1, 16'h20CC});
    direction = 1'b0;
    o_if.ready = 1'b0;
    a_if.valid = 1'b1; a_if.data = 16'h10AA; a_if.last = 1'b1;
    b_if.valid = 1'b1; b_if.data = 16'h20CC; b_if.last = 1'b1;
    @(negedge clk);
    chk("bp_a_ready_first", 32'(a_if.ready), 32'd1);
    chk("bp_b_ready_first", 32'(b_if.ready), 32'd0);
    @(posedge clk);
    #1;
    a_if.valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(o_if.valid), 32'd1);
      chk("bp_hold_data", 32'(o_if.data), 32'h10AA);
      chk("bp_a_ready", 32'(a_if.ready), 32'd0);
      chk("bp_b_ready", 32'(b_if.ready), 32'd0);
    end
    @(posedge clk);
    #1;
    o_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_b_ready_release", 32'(b_if.ready), 32'd1);
    @(posedge clk);
    #1;
    b_if.valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_all_out", 32'(exp_q.size()), 32'd0);
    chk("bp_state", 32'(state_dbg), 32'(MERGE));

    // Asynchronous reset while draining B.
    exp_q.push_back({1'b0, 16'h0101});
    a_if.valid = 1'b1; a_if.data = 16'h0101; a_if.last = 1'b1;
    b_if.valid = 1'b1; b_if.data = 16'h0202; b_if.last = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    a_if.valid = 1'b0;
    chk("drain_b_state", 32'(state_dbg), 32'(DRAIN_B));
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(o_if.valid), 32'd0);
    chk("arst_out_data", 32'(o_if.data), 32'd0);
    chk("arst_out_last", 32'(o_if.last), 32'd0);
    chk("arst_a_ready", 32'(a_if.ready), 32'd0);
    chk("arst_b_ready", 32'(b_if.ready), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(MERGE));
    chk("arst_exp_drained", 32'(exp_q.size()), 32'd0);
    b_if.valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fresh sequence after reset.
    run_vec(vecs[0]);
`ifdef STREAM_MERGE_CNT_EN
    chk("seq_cnt_after_rst", 32'(seq_cnt), 32'd4);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
